sysfiltr_cpu_ocimem_ctrl: RTL and testbench

SYSFILTR_CPU_OCIMEM_CTRL -- requirements
Module: sysfiltr_cpu_ocimem_ctrl

---
 rtl/sysfiltr_cpu_ocimem_pkg.sv | 23 ++
 rtl/sysfiltr_cpu_ocimem_if.sv | 25 ++
 rtl/sysfiltr_cpu_ocimem_timeout.sv | 30 +++
 rtl/sysfiltr_cpu_ocimem_ctrl.sv | 147 ++++++++++++++
 tb/tb_sysfiltr_cpu_ocimem_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sysfiltr_cpu_ocimem_pkg.sv
// rtl/sysfiltr_cpu_ocimem_pkg.sv - shared types and constants for the OCI debug-memory controller
// Contents: FSM state enum, jdo command-field bit positions, default ADDR_W / TIMEOUT_CYC.
package sysfiltr_cpu_ocimem_pkg;

  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_TIMEOUT_CYC = 255;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_MSB  = 33;
  localparam int JDO_ADDR_LSB  = 25;
  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_CLR_BIT   = 35;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } ocimem_state_e;

endpackage

// File: rtl/sysfiltr_cpu_ocimem_if.sv
// rtl/sysfiltr_cpu_ocimem_if.sv - debug-memory request/response bus
// Signals: mem_address/mem_read/mem_write/mem_writedata (request, master drives),
//          mem_waitrequest/mem_readdata/mem_readdatavalid (response, slave drives).
// Modports: master (controller side), slave (memory side).
interface sysfiltr_cpu_ocimem_if #(
  parameter int ADDR_W = sysfiltr_cpu_ocimem_pkg::DEF_ADDR_W
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_waitrequest, mem_readdata, mem_readdatavalid
  );
endinterface

// File: rtl/sysfiltr_cpu_ocimem_timeout.sv
// rtl/sysfiltr_cpu_ocimem_timeout.sv - cycle counter that flags a stalled memory handshake
// Ports: clk, reset_n (async active-low), run (count while high, clear while low),
//        expired (high during the TIMEOUT_CYC-th consecutive run cycle).
module sysfiltr_cpu_ocimem_timeout
  import sysfiltr_cpu_ocimem_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  // The count is of cycles already spent, so the limit is hit during the last allowed cycle.
  assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/sysfiltr_cpu_ocimem_ctrl.sv
// rtl/sysfiltr_cpu_ocimem_ctrl.sv - JTAG debug command to on-chip memory read/write controller
// Ports: clk, reset_n (async active-low); jdo + take_action_ocimem_a / take_no_action_ocimem_a /
//        take_action_ocimem_b (debug command pulses); mem (sysfiltr_cpu_ocimem_if.master);
//        MonDReg, MonAReg (monitor data/address), ocimem_busy, ocimem_error (sticky).
// Build option: define SYSFILTR_OCIMEM_TIMEOUT_EN to abort handshakes after TIMEOUT_CYC cycles.
module sysfiltr_cpu_ocimem_ctrl
  import sysfiltr_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  sysfiltr_cpu_ocimem_if.master mem,
  output logic [31:0]           MonDReg,
  output logic [ADDR_W-1:0]     MonAReg,
  output logic                  ocimem_busy,
  output logic                  ocimem_error
);
  ocimem_state_e state_q, state_d;
  logic          stream_q, stream_d;
  logic [31:0]   wdata_q;
  logic [1:0]    take_cnt;
  logic          err_set, err_clr, load_addr, load_wdata, rd_capture, incr_addr;
  logic          expired;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_CLR_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

`ifdef SYSFILTR_OCIMEM_TIMEOUT_EN
  sysfiltr_cpu_ocimem_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (ocimem_busy),
    .expired (expired)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign expired = 1'b0;
`endif

  assign take_cnt          = {1'b0, take_action_ocimem_a} + {1'b0, take_no_action_ocimem_a}
                           + {1'b0, take_action_ocimem_b};
  assign ocimem_busy       = (state_q != ST_IDLE);
  assign mem.mem_read      = (state_q == ST_RD_REQ);
  assign mem.mem_write     = (state_q == ST_WR_REQ);
  assign mem.mem_address   = MonAReg;
  assign mem.mem_writedata = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      stream_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stream_q <= stream_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stream_d   = stream_q;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    rd_capture = 1'b0;
    incr_addr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Address-load command has priority; colliding pulses are flagged.
        if (take_action_ocimem_a) begin
          load_addr = 1'b1;
          err_clr   = jdo[JDO_CLR_BIT];
          if (jdo[JDO_RD_BIT]) begin
            state_d  = ST_RD_REQ;
            stream_d = 1'b0;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d  = ST_RD_REQ;
          stream_d = 1'b1;
        end else if (take_action_ocimem_b) begin
          load_wdata = 1'b1;
          state_d    = ST_WR_REQ;
          stream_d   = 1'b1;
        end
        if (take_cnt > 2'd1) err_set = 1'b1;
      end
      ST_RD_REQ: begin
        if (!mem.mem_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem.mem_readdatavalid) begin
          rd_capture = 1'b1;
          incr_addr  = stream_q;
          state_d    = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (!mem.mem_waitrequest) begin
          incr_addr = stream_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ocimem_busy && (take_cnt != 2'd0)) err_set = 1'b1;
    // A stalled handshake is abandoned without touching the monitor registers.
    if (expired) begin
      state_d    = ST_IDLE;
      err_set    = 1'b1;
      rd_capture = 1'b0;
      incr_addr  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonAReg      <= '0;
      MonDReg      <= '0;
      wdata_q      <= '0;
      ocimem_error <= 1'b0;
    end else begin
      if (load_addr) begin
        MonAReg <= ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
      end else if (incr_addr) begin
        MonAReg <= MonAReg + ADDR_W'(1);
      end
      if (load_wdata) begin
        MonDReg <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        wdata_q <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
      end else if (rd_capture) begin
        MonDReg <= mem.mem_readdata;
      end
      if (err_set) begin
        ocimem_error <= 1'b1;
      end else if (err_clr) begin
        ocimem_error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sysfiltr_cpu_ocimem_ctrl.sv
// tb/tb_sysfiltr_cpu_ocimem_ctrl.sv - directed self-checking bench for sysfiltr_cpu_ocimem_ctrl
module tb_sysfiltr_cpu_ocimem_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b;
  logic [31:0] MonDReg;
  logic [8:0]  MonAReg;
  logic        ocimem_busy, ocimem_error;
  int          errors = 0;
  int          checks = 0;
  int          cyc;

  always #5 clk = ~clk;

  sysfiltr_cpu_ocimem_if #(.ADDR_W(9)) mem_if ();

  sysfiltr_cpu_ocimem_ctrl dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .mem                     (mem_if),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .ocimem_busy             (ocimem_busy),
    .ocimem_error            (ocimem_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [8:0] addr);
    logic [37:0] j;
    j        = '0;
    j[35]    = clr;
    j[34]    = rd;
    j[33:25] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j       = '0;
    j[34:3] = data;
    return j;
  endfunction

  task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] j);
    @(negedge clk);
    take_a = a; take_na = na; take_b = b; jdo = j;
    @(negedge clk);
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0; jdo = '0;
  endtask

  task automatic serve_read(input int waits, input logic [31:0] data, input logic [8:0] addr,
                            input string tag);
    for (int i = 0; i <= waits; i++) begin
      check({tag, " mem_read"}, 64'(mem_if.mem_read), 64'd1);
      check({tag, " rd_addr"}, 64'(mem_if.mem_address), 64'(addr));
      mem_if.mem_waitrequest = (i < waits);
      @(negedge clk);
    end
    mem_if.mem_waitrequest = 1'b0;
    check({tag, " rd_wait_busy"}, 64'(ocimem_busy), 64'd1);
    check({tag, " rd_wait_no_read"}, 64'(mem_if.mem_read), 64'd0);
    mem_if.mem_readdatavalid = 1'b1;
    mem_if.mem_readdata      = data;
    @(negedge clk);
    mem_if.mem_readdatavalid = 1'b0;
    mem_if.mem_readdata      = '0;
    check({tag, " rd_done_idle"}, 64'(ocimem_busy), 64'd0);
    check({tag, " rd_data"}, 64'(MonDReg), 64'(data));
  endtask

  task automatic serve_write(input int waits, input logic [8:0] addr, input logic [31:0] data,
                             input string tag);
    for (int i = 0; i <= waits; i++) begin
      check({tag, " mem_write"}, 64'(mem_if.mem_write), 64'd1);
      check({tag, " wr_addr"}, 64'(mem_if.mem_address), 64'(addr));
      check({tag, " wr_data"}, 64'(mem_if.mem_writedata), 64'(data));
      mem_if.mem_waitrequest = (i < waits);
      @(negedge clk);
    end
    mem_if.mem_waitrequest = 1'b0;
    check({tag, " wr_done_idle"}, 64'(ocimem_busy), 64'd0);
    check({tag, " wr_deassert"}, 64'(mem_if.mem_write), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0; take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    mem_if.mem_waitrequest = 1'b0; mem_if.mem_readdata = '0; mem_if.mem_readdatavalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst MonAReg", 64'(MonAReg), 64'd0);
    check("rst MonDReg", 64'(MonDReg), 64'd0);
    check("rst busy", 64'(ocimem_busy), 64'd0);
    check("rst error", 64'(ocimem_error), 64'd0);
    check("rst mem_read", 64'(mem_if.mem_read), 64'd0);
    check("rst mem_write", 64'(mem_if.mem_write), 64'd0);
    check("rst writedata", 64'(mem_if.mem_writedata), 64'd0);
    reset_n = 1'b1;

    // Address load with read, two wait cycles, no increment.
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 9'h010));
    serve_read(2, 32'hDEADBEEF, 9'h010, "ld_read");
    check("ld_read MonAReg", 64'(MonAReg), 64'h010);

    // Streaming write at the top address wraps to 0.
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 9'h1FF));
    check("ld_only idle", 64'(ocimem_busy), 64'd0);
    check("ld_only MonAReg", 64'(MonAReg), 64'h1FF);
    pulse(1'b0, 1'b0, 1'b1, jdo_b(32'h12345678));
    check("wr MonDReg", 64'(MonDReg), 64'h12345678);
    serve_write(0, 9'h1FF, 32'h12345678, "wr_wrap");
    check("wr_wrap MonAReg", 64'(MonAReg), 64'h000);

    // Three streaming reads from 0x020.
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 9'h020));
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1, 1'b0, '0);
      serve_read(i, 32'hA5A50000 + 32'(i), 9'(32'h20 + i), "stream");
    end
    check("stream MonAReg", 64'(MonAReg), 64'h023);

    // Stray readdatavalid in IDLE is ignored.
    mem_if.mem_readdatavalid = 1'b1; mem_if.mem_readdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_if.mem_readdatavalid = 1'b0; mem_if.mem_readdata = '0;
    check("stray rdv MonDReg", 64'(MonDReg), 64'hA5A50002);
    check("stray rdv idle", 64'(ocimem_busy), 64'd0);

    // Write pulse while in RD_WAIT is dropped and flags an error.
    pulse(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    take_b = 1'b1; jdo = jdo_b(32'h0BADF00D);
    @(negedge clk);
    take_b = 1'b0; jdo = '0;
    check("busy drop error", 64'(ocimem_error), 64'd1);
    check("busy drop no write", 64'(mem_if.mem_write), 64'd0);
    check("busy drop still busy", 64'(ocimem_busy), 64'd1);
    mem_if.mem_readdatavalid = 1'b1; mem_if.mem_readdata = 32'h11112222;
    @(negedge clk);
    mem_if.mem_readdatavalid = 1'b0; mem_if.mem_readdata = '0;
    check("busy drop rd MonDReg", 64'(MonDReg), 64'h11112222);
    check("busy drop rd MonAReg", 64'(MonAReg), 64'h024);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 9'h005));
    check("clr error", 64'(ocimem_error), 64'd0);
    check("clr MonAReg", 64'(MonAReg), 64'h005);

    // Simultaneous pulses: only the address load runs.
    pulse(1'b1, 1'b0, 1'b1, jdo_a(1'b0, 1'b0, 9'h030));
    check("multi MonAReg", 64'(MonAReg), 64'h030);
    check("multi idle", 64'(ocimem_busy), 64'd0);
    check("multi error", 64'(ocimem_error), 64'd1);
    check("multi MonDReg", 64'(MonDReg), 64'h11112222);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 9'h030));
    check("multi clr", 64'(ocimem_error), 64'd0);

    // Stalled read handshake.
    mem_if.mem_waitrequest = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, '0);
    cyc = 0;
    while (ocimem_busy && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
`ifdef SYSFILTR_OCIMEM_TIMEOUT_EN
    check("timeout cycles", 64'(cyc), 64'd255);
    check("timeout error", 64'(ocimem_error), 64'd1);
    check("timeout no read", 64'(mem_if.mem_read), 64'd0);
    check("timeout MonAReg", 64'(MonAReg), 64'h030);
    check("timeout MonDReg", 64'(MonDReg), 64'h11112222);
    mem_if.mem_waitrequest = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 9'h030));
`else
    check("stall cycles", 64'(cyc), 64'd300);
    check("stall busy", 64'(ocimem_busy), 64'd1);
    check("stall error", 64'(ocimem_error), 64'd0);
    serve_read(0, 32'h30303030, 9'h030, "stall");
    check("stall MonAReg", 64'(MonAReg), 64'h031);
`endif

    // Asynchronous reset in the middle of a write.
    mem_if.mem_waitrequest = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, jdo_b(32'hCAFEF00D));
    check("pre-rst mem_write", 64'(mem_if.mem_write), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst mem_write", 64'(mem_if.mem_write), 64'd0);
    check("async rst mem_read", 64'(mem_if.mem_read), 64'd0);
    check("async rst busy", 64'(ocimem_busy), 64'd0);
    check("async rst MonAReg", 64'(MonAReg), 64'd0);
    check("async rst MonDReg", 64'(MonDReg), 64'd0);
    check("async rst writedata", 64'(mem_if.mem_writedata), 64'd0);
    check("async rst error", 64'(ocimem_error), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_if.mem_waitrequest = 1'b0;
    @(negedge clk);
    check("post-rst idle", 64'(ocimem_busy), 64'd0);
    check("post-rst no write", 64'(mem_if.mem_write), 64'd0);
    check("post-rst MonAReg", 64'(MonAReg), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
